// File: rtl/game_pkg.sv
// Shared duck hunt definitions: screen size, duck hitbox defaults, shot FSM states, score width.
package game_pkg;

  localparam int unsigned X_POS_MAX  = 1024;
  localparam int unsigned Y_POS_MAX  = 768;
  localparam int unsigned DUCK_W_DEF = 64;
  localparam int unsigned DUCK_H_DEF = 64;
  localparam int unsigned SCORE_W    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCooldown,
    StEmpty
  } shot_state_t;

  // Score increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ctl_shot_hitbox.sv
// Combinational duck hitbox test: is the cursor inside a visible, not-yet-falling duck.
module ctl_shot_hitbox
  import game_pkg::*;
#(
  parameter int unsigned DUCK_W = DUCK_W_DEF,
  parameter int unsigned DUCK_H = DUCK_H_DEF
) (
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic [9:0] duck_x,
  input  logic [9:0] duck_y,
  input  logic       duck_show,
  input  logic       duck_hit,
  output logic       in_box
);

  // Box ends are formed at 11 bits so a duck near the right/bottom edge does not wrap to 0.
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_x;
  logic        in_y;

  // Compare the cursor against both box edges on each axis.
  always_comb begin
    x_end  = {1'b0, duck_x} + 11'(DUCK_W);
    y_end  = {1'b0, duck_y} + 11'(DUCK_H);
    in_x   = (mouse_x >= duck_x) && ({1'b0, mouse_x} < x_end);
    in_y   = (mouse_y >= duck_y) && ({1'b0, mouse_y} < y_end);
    in_box = duck_show && !duck_hit && in_x && in_y;
  end

endmodule

// File: rtl/ctl_shot.sv
// Shot controller: trigger edge detection, ammo/score bookkeeping and post-shot cooldown.
// Optional feature macro: CTL_SHOT_BONUS_AMMO_EN (a hit refunds the shot it used).
module ctl_shot
  import game_pkg::*;
#(
  parameter int unsigned AMMO_MAX        = 3,
  parameter int unsigned DUCK_W          = DUCK_W_DEF,
  parameter int unsigned DUCK_H          = DUCK_H_DEF,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_frame,
  input  logic                          game_start,
  input  logic                          trigger,
  input  logic [9:0]                    mouse_x,
  input  logic [9:0]                    mouse_y,
  input  logic [9:0]                    duck_x,
  input  logic [9:0]                    duck_y,
  input  logic                          duck_show,
  input  logic                          duck_hit,
  output logic                          hit,
  output logic                          miss,
  output logic                          no_ammo,
  output logic [$clog2(AMMO_MAX+1)-1:0] ammo,
  output logic [SCORE_W-1:0]            score
);

  localparam int unsigned AmmoW = $clog2(AMMO_MAX + 1);
  localparam int unsigned CntW  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  shot_state_t        state_q, state_d;
  logic [AmmoW-1:0]   ammo_q, ammo_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               trigger_last_q;
  logic               shot_edge;
  logic               in_box;

  ctl_shot_hitbox #(
    .DUCK_W (DUCK_W),
    .DUCK_H (DUCK_H)
  ) u_hitbox (
    .mouse_x   (mouse_x),
    .mouse_y   (mouse_y),
    .duck_x    (duck_x),
    .duck_y    (duck_y),
    .duck_show (duck_show),
    .duck_hit  (duck_hit),
    .in_box    (in_box)
  );

  assign shot_edge = trigger && !trigger_last_q;

  // Next-state, ammo/score update and hit/miss pulse generation; game_start overrides a shot.
  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (game_start) begin
      state_d = StArmed;
      ammo_d  = AmmoW'(AMMO_MAX);
      score_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (shot_edge) begin
            state_d = StCooldown;
            cnt_d   = '0;
            if (in_box) begin
              hit_d   = 1'b1;
              score_d = score_sat_inc(score_q);
`ifdef CTL_SHOT_BONUS_AMMO_EN
              // Decrement then refund; ammo never exceeds AMMO_MAX, so it is simply unchanged.
              ammo_d  = ammo_q;
`else
              ammo_d  = ammo_q - AmmoW'(1);
`endif
            end else begin
              miss_d = 1'b1;
              ammo_d = ammo_q - AmmoW'(1);
            end
          end
        end
        StCooldown: begin
          // Checked before counting so COOLDOWN_FRAMES=0 leaves after a single cycle.
          if (cnt_q == CntW'(COOLDOWN_FRAMES)) begin
            state_d = (ammo_q != '0) ? StArmed : StEmpty;
          end else if (new_frame) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StEmpty: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      ammo_q         <= '0;
      score_q        <= '0;
      cnt_q          <= '0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      trigger_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ammo_q         <= ammo_d;
      score_q        <= score_d;
      cnt_q          <= cnt_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      trigger_last_q <= trigger;
    end
  end

  assign hit     = hit_q;
  assign miss    = miss_q;
  assign no_ammo = (state_q == StEmpty);
  assign ammo    = ammo_q;
  assign score   = score_q;

endmodule

// File: tb/tb_ctl_shot.sv
// Self-checking bench for ctl_shot: table of single shots plus hand-written multi-cycle sequences.
module tb_ctl_shot;

  localparam int AMMO_MAX = 3;
`ifdef CTL_SHOT_BONUS_AMMO_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, new_frame, game_start, trigger;
  logic [9:0] mouse_x, mouse_y, duck_x, duck_y;
  logic       duck_show, duck_hit;
  logic       hit, miss, no_ammo;
  logic [1:0] ammo;
  logic [7:0] score;

  ctl_shot dut (
    .clk        (clk),
    .rst        (rst),
    .new_frame  (new_frame),
    .game_start (game_start),
    .trigger    (trigger),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .duck_show  (duck_show),
    .duck_hit   (duck_hit),
    .hit        (hit),
    .miss       (miss),
    .no_ammo    (no_ammo),
    .ammo       (ammo),
    .score      (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic       miss;
    logic [1:0] ammo;
    logic [7:0] score;
  } exp_t;

  typedef struct {
    string name;
    int    mx, my, dx, dy;
    bit    show, dhit, exp_hit;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Scoreboard: every hit/miss pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (hit || miss) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got hit=%0b miss=%0b, expected no pulse", hit, miss);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (hit !== e.hit || miss !== e.miss || ammo !== e.ammo || score !== e.score) begin
          n_fail++;
          $display("FAIL shot_result: got hit=%0b miss=%0b ammo=%0d score=%0d, expected hit=%0b miss=%0b ammo=%0d score=%0d",
                   hit, miss, ammo, score, e.hit, e.miss, e.ammo, e.score);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input bit h, input int am, input int sc);
    exp_t e;
    e.hit = h; e.miss = !h; e.ammo = 2'(am); e.score = 8'(sc);
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    cyc(1); game_start = 1'b1;
    cyc(1); game_start = 1'b0;
  endtask

  // One-cycle trigger press; the edge is sampled on the following clock.
  task automatic fire();
    cyc(1); trigger = 1'b1;
    cyc(1); trigger = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc(1); new_frame = 1'b1;
      cyc(1); new_frame = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no pulse, expected %0d pending pulse(s)", name, q.size());
      q.delete();
    end
  endtask

  task automatic set_miss_pos();
    duck_x = 10'd100; duck_y = 10'd200; duck_show = 1'b1; duck_hit = 1'b0;
    mouse_x = 10'd500; mouse_y = 10'd500;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"inside",       130, 230,  100, 200, 1, 0, 1};
    vecs[1] = '{"right_edge",   164, 230,  100, 200, 1, 0, 0};
    vecs[2] = '{"last_pixel",   163, 263,  100, 200, 1, 0, 1};
    vecs[3] = '{"left_of_box",   99, 230,  100, 200, 1, 0, 0};
    vecs[4] = '{"below_box",    130, 264,  100, 200, 1, 0, 0};
    vecs[5] = '{"top_left",     100, 200,  100, 200, 1, 0, 1};
    vecs[6] = '{"hidden_duck",  130, 230,  100, 200, 0, 0, 0};
    vecs[7] = '{"falling_duck", 130, 230,  100, 200, 1, 1, 0};
    vecs[8] = '{"no_wrap",     1020, 760, 1000, 740, 1, 0, 1};

    rst = 1'b1; new_frame = 1'b0; game_start = 1'b0; trigger = 1'b0;
    set_miss_pos();
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ammo", ammo, 0);
    chk("reset_score", score, 0);
    chk("reset_no_ammo", no_ammo, 0);
    chk("reset_pulses", {hit, miss}, 0);

    // Shots in IDLE are ignored.
    fire();
    cyc(2);
    chk("idle_ammo", ammo, 0);

    start_game();
    @(negedge clk);
    chk("start_ammo", ammo, AMMO_MAX);
    chk("start_score", score, 0);
    chk("start_no_ammo", no_ammo, 0);

    // Table of single shots, each from a fresh game.
    foreach (vecs[i]) begin
      start_game();
      mouse_x = 10'(vecs[i].mx); mouse_y = 10'(vecs[i].my);
      duck_x = 10'(vecs[i].dx);  duck_y = 10'(vecs[i].dy);
      duck_show = vecs[i].show;  duck_hit = vecs[i].dhit;
      push(vecs[i].exp_hit, (vecs[i].exp_hit && BONUS != 0) ? AMMO_MAX : AMMO_MAX - 1,
           vecs[i].exp_hit ? 1 : 0);
      fire();
      drain(vecs[i].name);
      cyc(2);
    end

    // Cooldown lockout: edge after 3 frames ignored, accepted after 8.
    set_miss_pos();
    start_game();
    push(0, AMMO_MAX - 1, 0);
    fire();
    drain("cooldown_first");
    frames(3);
    fire();
    cyc(2);
    @(negedge clk);
    chk("cooldown_locked_ammo", ammo, AMMO_MAX - 1);
    frames(5);
    cyc(2);
    push(0, AMMO_MAX - 2, 0);
    fire();
    drain("cooldown_rearmed");

    // Ammo exhaustion after three misses.
    start_game();
    for (int s = 0; s < 3; s++) begin
      push(0, AMMO_MAX - 1 - s, 0);
      fire();
      drain("exhaust_shot");
      if (s < 2) begin
        frames(8);
        cyc(2);
      end
    end
    @(negedge clk);
    chk("exhaust_no_ammo_early", no_ammo, 0);
    frames(7);
    @(negedge clk);
    chk("exhaust_no_ammo_7", no_ammo, 0);
    frames(1);
    cyc(2);
    @(negedge clk);
    chk("exhaust_no_ammo_8", no_ammo, 1);
    fire();
    cyc(2);
    @(negedge clk);
    chk("empty_ammo", ammo, 0);
    chk("empty_no_ammo_held", no_ammo, 1);
    start_game();
    @(negedge clk);
    chk("reload_no_ammo", no_ammo, 0);
    chk("reload_ammo", ammo, AMMO_MAX);

    // game_start and a trigger edge in the same cycle: the edge is discarded.
    cyc(1); game_start = 1'b1; trigger = 1'b1;
    cyc(1); game_start = 1'b0; trigger = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("start_vs_trigger_ammo", ammo, AMMO_MAX);

    // Trigger held across the whole cooldown fires only once.
    cyc(1); trigger = 1'b1;
    push(0, AMMO_MAX - 1, 0);
    drain("held_first");
    frames(8);
    cyc(4);
    @(negedge clk);
    chk("held_trigger_ammo", ammo, AMMO_MAX - 1);
    trigger = 1'b0;
    cyc(2);

    // Score accumulates across hits in one game.
    start_game();
    duck_x = 10'd100; duck_y = 10'd200; mouse_x = 10'd130; mouse_y = 10'd230;
    push(1, BONUS != 0 ? AMMO_MAX : AMMO_MAX - 1, 1);
    fire();
    drain("score_hit1");
    frames(8);
    cyc(2);
    push(1, BONUS != 0 ? AMMO_MAX : AMMO_MAX - 2, 2);
    fire();
    drain("score_hit2");

    // Reset mid-cooldown returns everything to reset values.
    frames(2);
    cyc(1); rst = 1'b1;
    cyc(1); rst = 1'b0;
    @(negedge clk);
    chk("midcool_rst_ammo", ammo, 0);
    chk("midcool_rst_score", score, 0);
    chk("midcool_rst_no_ammo", no_ammo, 0);

    // Reset coinciding with a trigger edge in ARMED suppresses the pulse.
    start_game();
    cyc(1); rst = 1'b1; trigger = 1'b1;
    cyc(1); rst = 1'b0; trigger = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("rst_vs_trigger_ammo", ammo, 0);

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
